// File: rtl/i2c_master.sv
// I2C initiator for one single-byte register write or read (repeated START) per request.
// SDA is split into a drive line (sda_out, 1 = released) and a return line (sda_in).
module i2c_master #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int SCL_FREQ = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [7:0] rdata,
  output logic       scl,
  output logic       sda_out,
  input  logic       sda_in,
  output logic [3:0] dbg_state
);

  localparam int Q  = CLK_FREQ / (4 * SCL_FREQ);
  localparam int QW = (Q > 1) ? $clog2(Q) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR_W, S_ADDR_W_ACK, S_REG, S_REG_ACK, S_WDATA, S_WDATA_ACK,
    S_RSTART, S_ADDR_R, S_ADDR_R_ACK, S_RDATA, S_RDATA_NACK, S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt;
  logic [1:0]    phase;
  logic [2:0]    bit_cnt;
  logic          rw_q;
  logic [6:0]    addr_q;
  logic [7:0]    reg_q, wdata_q, rx_sr, tx_byte;
  logic          q_last, slot_end, sample, bit_last, accept, is_byte, is_ack, is_bit;

  // Handshake: start is taken only in a cycle with busy=0 and done=0 (never queued);
  // done is a one-cycle pulse with no back-pressure, rdata/ack_error valid alongside it.
  assign accept   = (state_q == S_IDLE) && start && !done;
  assign q_last   = (qcnt == QW'(Q - 1));
  assign slot_end = q_last && (phase == 2'd3);
  assign sample   = q_last && (phase == 2'd1);
  assign bit_last = (bit_cnt == 3'd7);
  assign is_byte  = state_q inside {S_ADDR_W, S_REG, S_WDATA, S_ADDR_R, S_RDATA};
  assign is_ack   = state_q inside {S_ADDR_W_ACK, S_REG_ACK, S_WDATA_ACK, S_ADDR_R_ACK};
  assign is_bit   = is_byte || is_ack || (state_q == S_RDATA_NACK);

  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    scl     = 1'b1;
    sda_out = 1'b1;
    tx_byte = 8'hFF;
    case (state_q)
      S_IDLE: if (accept) state_d = S_START;
      S_START: begin
        scl     = (phase != 2'd3);
        sda_out = (phase == 2'd0);
        if (slot_end) state_d = S_ADDR_W;
      end
      S_ADDR_W: begin
        tx_byte = {addr_q, 1'b0};
        if (slot_end && bit_last) state_d = S_ADDR_W_ACK;
      end
      S_ADDR_W_ACK: if (slot_end) state_d = ack_error ? S_STOP : S_REG;
      S_REG: begin
        tx_byte = reg_q;
        if (slot_end && bit_last) state_d = S_REG_ACK;
      end
      S_REG_ACK: begin
        if (slot_end) begin
          if (ack_error) state_d = S_STOP;
          else           state_d = rw_q ? S_RSTART : S_WDATA;
        end
      end
      S_WDATA: begin
        tx_byte = wdata_q;
        if (slot_end && bit_last) state_d = S_WDATA_ACK;
      end
      S_WDATA_ACK: if (slot_end) state_d = S_STOP;
      S_RSTART: begin
        scl     = (phase != 2'd0);
        sda_out = !phase[1];
        if (slot_end) state_d = S_ADDR_R;
      end
      S_ADDR_R: begin
        tx_byte = {addr_q, 1'b1};
        if (slot_end && bit_last) state_d = S_ADDR_R_ACK;
      end
      S_ADDR_R_ACK: if (slot_end) state_d = ack_error ? S_STOP : S_RDATA;
      S_RDATA:      if (slot_end && bit_last) state_d = S_RDATA_NACK;
      S_RDATA_NACK: if (slot_end) state_d = S_STOP;
      S_STOP: begin
        scl     = (phase != 2'd0);
        sda_out = phase[1];
        if (slot_end) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Bit slots: SCL high in q1..q2; ACK/NACK/RDATA slots keep tx_byte all-ones (released).
    if (is_bit) begin
      scl     = (phase == 2'd1) || (phase == 2'd2);
      sda_out = tx_byte[3'd7 - bit_cnt];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      qcnt      <= '0;
      phase     <= 2'd0;
      bit_cnt   <= 3'd0;
      rw_q      <= 1'b0;
      addr_q    <= 7'd0;
      reg_q     <= 8'd0;
      wdata_q   <= 8'd0;
      rx_sr     <= 8'd0;
      ack_error <= 1'b0;
      rdata     <= 8'd0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Realign the quarter counter so the frame starts on q0 the cycle after accept.
        qcnt      <= '0;
        phase     <= 2'd0;
        bit_cnt   <= 3'd0;
        rw_q      <= rw;
        addr_q    <= slave_addr;
        reg_q     <= reg_addr;
        wdata_q   <= wdata;
        ack_error <= 1'b0;
      end else begin
        qcnt <= q_last ? '0 : qcnt + 1'b1;
        if (q_last) phase <= phase + 2'd1;
        if (slot_end && is_byte) bit_cnt <= bit_cnt + 3'd1;
        if (sample && is_ack) ack_error <= ack_error | sda_in;
        if (sample && (state_q == S_RDATA)) rx_sr <= {rx_sr[6:0], sda_in};
        if (slot_end && (state_q == S_STOP)) begin
          done <= 1'b1;
          if (rw_q && !ack_error) rdata <= rx_sr;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: directed transactions against a behavioural slave on the split SDA bus.
module tb_i2c_master;

  localparam int CLK_FREQ = 1600;
  localparam int SCL_FREQ = 100;
  localparam int Q        = 4;
  localparam logic [6:0] SLAVE_ADDR = 7'h68;
  localparam logic [3:0] EV_START = 4'd1, EV_STOP = 4'd2, EV_BYTE = 4'd3, EV_ACK = 4'd4;

  logic       clk = 1'b0;
  logic       rst, start, rw;
  logic [6:0] slave_addr;
  logic [7:0] reg_addr, wdata, rdata;
  logic       busy, done, ack_error, scl, sda_out, sda_in;
  logic [3:0] dbg_state;
  logic       slave_sda = 1'b1;

  assign sda_in = sda_out & slave_sda;

  i2c_master #(.CLK_FREQ(CLK_FREQ), .SCL_FREQ(SCL_FREQ)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .slave_addr(slave_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .ack_error(ack_error),
    .rdata(rdata), .scl(scl), .sda_out(sda_out), .sda_in(sda_in), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];     // bus events {type, data}
  logic [40:0] done_q[$];    // {done cycle, ack_error, rdata}
  logic [7:0]  model_rdata = 8'h00;
  logic [7:0]  rd_byte     = 8'h68;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ev(input logic [3:0] t, input logic [7:0] d);
    return {t, d};
  endfunction

  task automatic bus_event(input logic [11:0] e);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL bus_extra actual=%0h expected=none (cycle %0d)", e, cyc);
    end else begin
      check("bus_event", {20'd0, e}, {20'd0, exp_q.pop_front()});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic expect_bus(input logic r, input logic [6:0] a, input logic [7:0] rg,
                            input logic [7:0] d, input bit aborted);
    logic nack;
    nack = (a != SLAVE_ADDR);
    exp_q.push_back(ev(EV_START, 8'h00));
    exp_q.push_back(ev(EV_BYTE, {a, 1'b0}));
    exp_q.push_back(ev(EV_ACK, {7'd0, nack}));
    if (aborted) return;
    if (!nack) begin
      exp_q.push_back(ev(EV_BYTE, rg));
      exp_q.push_back(ev(EV_ACK, 8'h00));
      if (!r) begin
        exp_q.push_back(ev(EV_BYTE, d));
        exp_q.push_back(ev(EV_ACK, 8'h00));
      end else begin
        exp_q.push_back(ev(EV_START, 8'h00));
        exp_q.push_back(ev(EV_BYTE, {a, 1'b1}));
        exp_q.push_back(ev(EV_ACK, 8'h00));
        exp_q.push_back(ev(EV_BYTE, rd_byte));
        exp_q.push_back(ev(EV_ACK, 8'h01));
      end
    end
    exp_q.push_back(ev(EV_STOP, 8'h00));
  endtask

  // Called #1 after a posedge in a cycle where the DUT is idle and not pulsing done.
  task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] rg,
                       input logic [7:0] d, input bit aborted, output int t0);
    logic nack;
    int   lat;
    nack = (a != SLAVE_ADDR);
    lat  = nack ? 177 : (r ? 625 : 465);
    expect_bus(r, a, rg, d, aborted);
    rw = r; slave_addr = a; reg_addr = rg; wdata = d; start = 1'b1;
    t0 = cyc;
    if (r && !nack) model_rdata = rd_byte;
    if (!aborted) done_q.push_back({32'(t0 + lat), nack, model_rdata});
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_scl"},       {31'd0, scl},       32'd1);
    check({tag, "_sda_out"},   {31'd0, sda_out},   32'd1);
    check({tag, "_busy"},      {31'd0, busy},      32'd0);
    check({tag, "_done"},      {31'd0, done},      32'd0);
    check({tag, "_ack_error"}, {31'd0, ack_error}, 32'd0);
    check({tag, "_rdata"},     {24'd0, rdata},     32'd0);
    check({tag, "_state"},     {28'd0, dbg_state}, 32'd0);
  endtask

  // ---------------- monitor: bus decode, slave model, done scoreboard ----------------
  logic       prev_scl, prev_sda, first, addressed, slave_tx, pend_tx, saw_start;
  logic       scl_now, sda_now;
  logic [7:0] shift;
  int         bit_cnt, high_cnt;
  logic [40:0] de;

  initial begin
    forever begin
      @(negedge clk);
      if (rst !== 1'b1) begin
        prev_scl = 1'b1; prev_sda = 1'b1; first = 1'b0; addressed = 1'b0;
        slave_tx = 1'b0; pend_tx = 1'b0; saw_start = 1'b1; shift = 8'h00;
        bit_cnt = 0; high_cnt = 0; slave_sda = 1'b1;
      end else begin
        scl_now = scl;
        sda_now = sda_in;
        if (prev_scl && scl_now && prev_sda && !sda_now) begin
          bus_event(ev(EV_START, 8'h00));
          bit_cnt = 0; shift = 8'h00; first = 1'b1; addressed = 1'b0;
          slave_tx = 1'b0; pend_tx = 1'b0; slave_sda = 1'b1; saw_start = 1'b1;
        end else if (prev_scl && scl_now && !prev_sda && sda_now) begin
          bus_event(ev(EV_STOP, 8'h00));
          bit_cnt = 0; first = 1'b0; addressed = 1'b0;
          slave_tx = 1'b0; pend_tx = 1'b0; slave_sda = 1'b1;
        end else if (!prev_scl && scl_now) begin
          high_cnt = 0;
          saw_start = 1'b0;
          if (bit_cnt < 8) begin
            shift = {shift[6:0], sda_now};
            bit_cnt++;
          end else if (bit_cnt == 9) begin
            bus_event(ev(EV_ACK, {7'd0, sda_now}));
          end
        end else if (prev_scl && !scl_now) begin
          if (!saw_start) check("scl_high_time", high_cnt, 2 * Q);
          if (bit_cnt == 8) begin
            bus_event(ev(EV_BYTE, shift));
            if (slave_tx) begin
              slave_tx  = 1'b0;
              slave_sda = 1'b1;
            end else begin
              if (first) begin
                addressed = (shift[7:1] == SLAVE_ADDR);
                pend_tx   = addressed & shift[0];
              end
              slave_sda = !addressed;
            end
            first   = 1'b0;
            bit_cnt = 9;
          end else if (bit_cnt == 9) begin
            bit_cnt   = 0;
            slave_sda = 1'b1;
            if (pend_tx) begin
              pend_tx   = 1'b0;
              slave_tx  = 1'b1;
              slave_sda = rd_byte[7];
            end
          end else if (slave_tx) begin
            slave_sda = rd_byte[7 - bit_cnt];
          end
        end
        if (scl_now) high_cnt++;
        prev_scl = scl_now;
        prev_sda = sda_now;

        if (done === 1'b1) begin
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_extra actual=1 expected=0 (cycle %0d)", cyc);
          end else begin
            de = done_q.pop_front();
            check("done_cycle", cyc, de[40:9]);
            check("done_ack_error", {31'd0, ack_error}, {31'd0, de[8]});
            check("done_rdata", {24'd0, rdata}, {24'd0, de[7:0]});
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    checks++;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- directed sequence ----------------
  initial begin
    int t0;
    rst = 1'b0; start = 1'b0; rw = 1'b0;
    slave_addr = 7'd0; reg_addr = 8'd0; wdata = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Register write 0x6B <= 0x00
    issue(1'b0, 7'h68, 8'h6B, 8'h00, 1'b0, t0);
    wait_until(t0 + 465);
    // start in the done cycle is ignored; the next cycle accepts the read
    start = 1'b1; rw = 1'b1; slave_addr = 7'h68; reg_addr = 8'h75; wdata = 8'h00;
    @(posedge clk); #1;
    check("start_at_done_ignored", {31'd0, busy}, 32'd0);

    // Register read 0x75 -> 0x68
    issue(1'b1, 7'h68, 8'h75, 8'h00, 1'b0, t0);
    wait_until(t0 + 627);

    // Write with a conflicting start pulse mid-frame
    issue(1'b0, 7'h68, 8'h1C, 8'hA5, 1'b0, t0);
    wait_until(t0 + 200);
    start = 1'b1; rw = 1'b1; slave_addr = 7'h11; reg_addr = 8'hFF; wdata = 8'hEE;
    @(posedge clk); #1;
    start = 1'b0;
    wait_until(t0 + 467);

    // Address NACK: no slave at 0x69
    issue(1'b0, 7'h69, 8'h3B, 8'h00, 1'b0, t0);
    wait_until(t0 + 179);

    // Reset in the middle of a frame (low phase of the failed ACK slot)
    issue(1'b0, 7'h69, 8'h3B, 8'h00, 1'b1, t0);
    wait_until(t0 + 158);
    check("abort_pre_ack_error", {31'd0, ack_error}, 32'd1);
    check("abort_pre_scl", {31'd0, scl}, 32'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    model_rdata = 8'h00;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Recovery write after the abort
    issue(1'b0, 7'h68, 8'h6B, 8'h01, 1'b0, t0);
    wait_until(t0 + 467);

    check("bus_events_left", exp_q.size(), 0);
    check("done_left", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
# i2c_master

I2C controller for the MPU-6050 link on the Arty A7; it is the initiator that drives the bus the `i2c_slave` responder listens to. One `start` request runs one complete single-byte register transaction: write (START, addr+W, reg, data, STOP) or read (START, addr+W, reg, repeated START, addr+R, data, NACK, STOP). SDA is modelled as a separate drive line and return line (`sda_out` driven, `sda_in` received), matching the slave's port split; top level merges them onto the open-drain pad.

## Interface
- `CLK_FREQ`, 100_000_000: `clk` frequency in Hz.
- `SCL_FREQ`, 100_000: SCL frequency in Hz. Quarter period `Q = CLK_FREQ/(4*SCL_FREQ)` clocks, truncated; `Q >= 2` is required.
- `clk`  in  1  system clock; everything is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; accepted only when `busy=0`.
- `rw`  in  1  0 = write, 1 = read; latched at accept.
- `slave_addr`  in  7  device address, latched at accept (MPU-6050: 0x68).
- `reg_addr`  in  8  register address, latched at accept.
- `wdata`  in  8  write byte, latched at accept.
- `busy`  out  1  transaction in progress.
- `done`  out  1  one-cycle pulse at transaction end.
- `ack_error`  out  1  a slave ACK slot read 1; sticky until the next accept.
- `rdata`  out  8  last byte read.
- `scl`  out  1  serial clock.
- `sda_out`  out  1  SDA drive value (1 = released/high).
- `sda_in`  in  1  SDA as seen on the bus.

## Operation
- Reset (`rst=0`, takes effect immediately) sets `scl=1`, `sda_out=1`, `busy=0`, `done=0`, `ack_error=0`, `rdata=0`, and state IDLE. Reset in the middle of a frame abandons it with no STOP sent.
- States: IDLE, START, ADDR_W, ADDR_W_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RSTART, ADDR_R, ADDR_R_ACK, RDATA, RDATA_NACK, STOP.
- Transitions:
  - IDLE to START on `start & ~busy`; inputs are latched and `ack_error` is cleared.
  - START to ADDR_W to ADDR_W_ACK to REG to REG_ACK.
  - REG_ACK to WDATA (rw=0) or to RSTART (rw=1).
  - WDATA to WDATA_ACK to STOP.
  - RSTART to ADDR_R to ADDR_R_ACK to RDATA to RDATA_NACK to STOP.
  - STOP to IDLE.
- Bytes are sent MSB first. Address bytes are `{slave_addr, 0}` in ADDR_W and `{slave_addr, 1}` in ADDR_R.
- In any *_ACK state a sampled `sda_in=1` sets `ack_error` and goes straight to STOP; the rest of the frame is skipped.
- In RDATA the 8 sampled bits are shifted into an internal register. RDATA_NACK drives `sda_out=1`.
- `rdata` is loaded only on a successful read, in the cycle `done` pulses. It holds its value on writes and on ACK errors.
- `start` asserted while busy is ignored; the request is not queued.

## Timing
- A free-running quarter counter 0..Q-1 advances the phase; each state lasts 4 quarters, q0..q3.
- Data/ACK/NACK bit:
  - q0: `scl=0`, `sda_out` updated at the start of q0.
  - q1, q2: `scl=1`.
  - q3: `scl=0`.
  - `sda_in` is sampled on the last clock of q1, which is mid-high. During ACK slots the master drives `sda_out=1`.
- START: `scl=1` in q0..q2, 0 in q3; `sda_out=1` in q0, 0 in q1..q3.
- RSTART: `sda_out=1` in q0..q1, 0 in q2..q3; `scl=0` in q0, 1 in q1..q3.
- STOP: `scl=0` in q0, 1 in q1..q3; `sda_out=0` in q0..q1, 1 in q2..q3.
- SDA never changes while SCL is high, except at the START/RSTART/STOP edges listed above.
- Accept cycle is T0; `busy=1` from T0+1.
- Frame length is 116·Q clocks for a write and 156·Q for a read. An ACK error shortens the frame to (4 + 36·k + 4)·Q, where k is the number of completed byte+ACK slots.
- `done` pulses in the cycle after the last STOP quarter; `busy` falls in that same cycle. `start` can be accepted again on the following cycle.
- Simultaneous `done` and `start`: `start` is ignored in that cycle.

## Test plan
- Reset: hold `rst=0` mid-frame → outputs return to `scl=1`, `sda_out=1`, `busy=0`, `done=0`, `ack_error=0`, `rdata=0` in the same cycle.
- Write, with CLK_FREQ=1600, SCL_FREQ=100 (Q=4), and a slave model ACKing everything: rw=0, addr 0x68, reg 0x6B, data 0x00 → bytes 0xD0, 0x6B, 0x00 on the bus; `done` at T0+465; `ack_error=0`.
- Read: rw=1, reg 0x75, slave returns 0x68 → bytes 0xD0, 0x75, RSTART, 0xD1, master NACK, STOP; `rdata=0x68` at `done` (T0+625).
- Address NACK: slave model silent, addr 0x69 → `ack_error=1`, STOP right after the first ACK slot, `done` at T0+177, `rdata` unchanged.
- Busy rejection: pulse `start` mid-frame with different inputs → bus stream unchanged; `done` pulses exactly once.
- Protocol checker over all runs: SDA never toggles while SCL is high except at START/RSTART/STOP; SCL high time is 2·Q.
